memory_readback: RTL

MEMORY_READBACK -- requirements
Module: memory_readback

---
 rtl/memory_readback_pkg.sv | 39 +++
 rtl/memory_readback_if.sv | 45 ++++
 rtl/memory_readback_mem_16x16.sv | 55 +++++
 rtl/memory_readback.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/memory_readback_pkg.sv
// -----------------------------------------------------------------------------
// memory_readback_pkg
//
// Shared definitions for the memory readback checker:
//   - geometry of the checked memory (DEPTH x WIDTH, ADDR_W address bits)
//   - width of the mismatch counter and of the per-address hold counter
//   - FSM state encoding
//   - expected_word(): the reference pattern every address is checked against
// -----------------------------------------------------------------------------
package memory_readback_pkg;

  localparam int DEPTH  = 16;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 4;

  // Mismatch counter must reach DEPTH (all words wrong), hence one extra bit.
  localparam int ERR_W  = 5;

  // Hold counter covers the legal HOLD_CYCLES range 1..15.
  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Expected word for an address: the low (addr+1) bits set.
  // addr 0 -> 0x0001, addr 1 -> 0x0003, ... addr 15 -> 0xFFFF.
  function automatic logic [WIDTH-1:0] expected_word(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] word;
    word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i <= int'(addr)) word[i] = 1'b1;
    end
    return word;
  endfunction

endpackage : memory_readback_pkg

// File: rtl/memory_readback_if.sv
// -----------------------------------------------------------------------------
// memory_readback_if
//
// Bundles the upstream writer / readback request signals and the readback
// status outputs of memory_readback.
//   master : the environment (writer + requester), drives write side + start
//   slave  : memory_readback itself
//
// Signals
//   write, enable   write strobe and memory enable (write needs both high)
//   address, data_in  write address / data
//   start_read      level request to begin a readback
//   rd_addr         address currently being read
//   data_out        registered read data
//   valid           one-cycle pulse: data_out has been checked
//   busy, done      high while in READ / DONE
//   err_cnt         mismatches found in the last readback (0..16)
// -----------------------------------------------------------------------------
interface memory_readback_if;
  import memory_readback_pkg::*;

  logic              write;
  logic              enable;
  logic [ADDR_W-1:0] address;
  logic [WIDTH-1:0]  data_in;
  logic              start_read;

  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  data_out;
  logic              valid;
  logic              busy;
  logic              done;
  logic [ERR_W-1:0]  err_cnt;

  modport master (
    output write, enable, address, data_in, start_read,
    input  rd_addr, data_out, valid, busy, done, err_cnt
  );

  modport slave (
    input  write, enable, address, data_in, start_read,
    output rd_addr, data_out, valid, busy, done, err_cnt
  );

endinterface : memory_readback_if

// File: rtl/memory_readback_mem_16x16.sv
// -----------------------------------------------------------------------------
// mem_16x16
//
// 16-entry x 16-bit storage with synchronous write, registered read and a
// synchronous clear that zeroes every word and the read register.
//
// Ports
//   clk_i      clock, all activity on the rising edge
//   clr_i      synchronous clear (priority over write and read)
//   we_i       write enable
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    when high the read register loads mem[rd_addr_i]; otherwise
//              it holds its previous value
//   rd_addr_i  read address
//   rd_data_o  registered read data (one cycle latency)
// -----------------------------------------------------------------------------
module mem_16x16
  import memory_readback_pkg::*;
(
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      // NOTE: the array is cleared word by word on purpose; a clear to a known
      // value is part of this block's behaviour, so the storage is built from
      // flops rather than an inferred RAM macro that could not be reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
        rd_data_q <= mem_q[rd_addr_i];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : mem_16x16

// File: rtl/memory_readback.sv
// -----------------------------------------------------------------------------
// memory_readback
//
// Holds a 16x16 memory that an upstream writer fills, then on request walks
// every address, holding each one HOLD_CYCLES cycles, and compares the word
// read back against the expected pattern (low addr+1 bits set). Mismatches
// are counted in err_cnt.
//
// Parameters
//   HOLD_CYCLES  cycles each read address is held, legal range 1..15
//
// Ports
//   clk_fnl  single clock, rising edge
//   rst      synchronous active-high reset; clears FSM, counters, outputs
//            and every memory word
//   bus      memory_readback_if.slave (write side, start_read, status)
//
// Timing of one address a (first cycle of a = cycle t):
//   t   : rd_addr = a, memory read issued
//   t+1 : data_out = mem[a], valid = 1
//   t+2 : err_cnt reflects the comparison of mem[a]
// With HOLD_CYCLES = 1 the valid pulse for address 15 lands in the first
// DONE cycle, so the address of the data being checked is tracked separately
// from rd_addr.
// -----------------------------------------------------------------------------
module memory_readback
  import memory_readback_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk_fnl,
  input  logic       rst,
  memory_readback_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] chk_addr_q;   // address whose data is in data_out
  logic [HOLD_W-1:0] hold_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [ERR_W-1:0]  err_q;

  logic              in_read;
  logic              mem_we;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_data_ok;

  assign in_read = (state_q == ST_READ);

  // The writer is locked out for the whole readback so the walk sees a
  // stable memory image.
  assign mem_we  = bus.enable & bus.write & ~in_read;

  mem_16x16 u_mem (
    .clk_i     (clk_fnl),
    .clr_i     (rst),
    .we_i      (mem_we),
    .wr_addr_i (bus.address),
    .wr_data_i (bus.data_in),
    .rd_en_i   (in_read),
    .rd_addr_i (rd_addr_q),
    .rd_data_o (rd_data)
  );

  assign rd_data_ok = (rd_data == expected_word(chk_addr_q));

  always_ff @(posedge clk_fnl) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= '0;
      chk_addr_q <= '0;
      hold_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      valid_q <= 1'b0;

      // The comparison runs on whatever cycle valid is high, which for
      // HOLD_CYCLES = 1 includes the first DONE cycle.
      if (valid_q && !rd_data_ok) begin
        err_q <= err_q + ERR_W'(1);
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start_read) begin
            // NOTE: with non-blocking assignments the last one in the block
            // wins, so this clear of err_q deliberately overrides a pending
            // increment from a valid pulse in the same cycle.
            state_q   <= ST_READ;
            rd_addr_q <= '0;
            hold_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end

        ST_READ: begin
          // First cycle of an address: its data appears next cycle.
          if (hold_q == '0) begin
            valid_q    <= 1'b1;
            chk_addr_q <= rd_addr_q;
          end

          if (hold_q == HOLD_LAST) begin
            hold_q <= '0;
            if (rd_addr_q == ADDR_LAST) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_addr  = rd_addr_q;
  assign bus.data_out = rd_data;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err_cnt  = err_q;

endmodule : memory_readback
